// File: rtl/kd_cluster_pe_if.sv
// Point handshake between a k-d tree PE and its point source.
// pt_valid/pt_ready: a point transfers on any clock edge where both are high; pt_in and pt_assign are held while pt_valid waits.
interface kd_cluster_pe_if #(
    parameter int DIM = 3,
    parameter int DW  = 8
) ();
    logic              pt_valid;
    logic              pt_ready;
    logic              pt_assign;
    logic [DIM*DW-1:0] pt_in;
    logic              go_left;

    modport master (output pt_valid, pt_in, pt_assign, input pt_ready, go_left);
    modport slave  (input pt_valid, pt_in, pt_assign, output pt_ready, go_left);
endinterface

// File: rtl/kd_cluster_pe.sv
// k-d tree cluster PE: routes points on the depth axis, accumulates assigned points,
// divides serially for a new centroid and swaps centers with parent/child under a ttl.
module kd_cluster_pe #(
    parameter int                DIM         = 3,
    parameter int                DW          = 8,
    parameter int                MAX_N       = 1024,
    parameter int                MAX_DEPTH   = 16,
    parameter logic [DIM*DW-1:0] INIT_CENTER = '0,
    localparam int               CW          = $clog2(MAX_N + 1),
    localparam int               AW          = DW + CW,
    localparam int               DPW         = $clog2(MAX_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DPW-1:0]    depth,
    input  logic              level_load,
    input  logic              next_level,
    kd_cluster_pe_if.slave    pt,
    input  logic              update_start,
    output logic              busy,
    output logic              done,
    output logic              stable,
    output logic [CW-1:0]     count,
    input  logic              parent_swap,
    input  logic              child_swap,
    input  logic [DIM*DW-1:0] parent_in,
    input  logic [DIM*DW-1:0] child_in,
    output logic [DIM*DW-1:0] parent_out,
    output logic [DIM*DW-1:0] child_out,
    output logic [DIM*DW-1:0] center,
    output logic [DPW-1:0]    child_depth,
    output logic [1:0]        fsm_state
);
    localparam int BW = $clog2(AW + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, DIVIDE = 2'd1, COMMIT = 2'd2} state_t;
    state_t state_q, state_nxt;

    logic [AW-1:0]  sums    [DIM];
    logic [AW-1:0]  sum_nxt [DIM];
    logic [CW-1:0]  rem     [DIM];
    logic [CW:0]    trial   [DIM];
    logic [DIM-1:0] q_bit;
    logic [DIM-1:0] eq;
    logic [CW-1:0]  cnt_nxt;
    logic [BW-1:0]  bit_cnt;
    logic [DPW-1:0] ttl;
    logic [DW-1:0]  pt_axis, ctr_axis;
    logic           accept, take, swap_ok, do_parent, do_child;

    assign pt.pt_ready  = (state_q == IDLE) && en && (count < CW'(MAX_N));
    assign accept       = pt.pt_valid && pt.pt_ready;
    assign take         = accept && pt.pt_assign;
    assign swap_ok      = en && (state_q == IDLE) && (ttl != '0);
    assign do_parent    = swap_ok && parent_swap;
    assign do_child     = swap_ok && child_swap && !parent_swap;
    assign busy         = (state_q == DIVIDE);
    assign child_depth  = depth + DPW'(1);
    assign fsm_state    = state_q;

    // In DIVIDE each sums lane doubles as the dividend shift register; quotient bits enter at the LSB.
    always_comb begin
        cnt_nxt  = count + CW'(take);
        pt_axis  = '0;
        ctr_axis = '0;
        q_bit    = '0;
        eq       = '0;
        for (int d = 0; d < DIM; d++) begin
            sum_nxt[d] = sums[d] + (take ? AW'(pt.pt_in[d*DW +: DW]) : AW'(0));
            trial[d]   = {rem[d], sums[d][AW-1]};
            q_bit[d]   = (trial[d] >= {1'b0, count});
            eq[d]      = (sums[d][DW-1:0] == center[d*DW +: DW]);
            if ((int'(depth) % DIM) == d) begin
                pt_axis  = pt.pt_in[d*DW +: DW];
                ctr_axis = center[d*DW +: DW];
            end
        end
    end

    always_comb begin
        state_nxt = state_q;
        if (en) begin
            case (state_q)
                IDLE:    if (update_start && cnt_nxt != '0) state_nxt = DIVIDE;
                DIVIDE:  if (bit_cnt == BW'(AW - 1)) state_nxt = COMMIT;
                COMMIT:  state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            center     <= INIT_CENTER;
            count      <= '0;
            ttl        <= '0;
            parent_out <= '0;
            child_out  <= '0;
            pt.go_left <= 1'b0;
            stable     <= 1'b0;
            done       <= 1'b0;
            bit_cnt    <= '0;
            for (int d = 0; d < DIM; d++) begin
                sums[d] <= '0;
                rem[d]  <= '0;
            end
        end else if (en) begin
            done <= 1'b0;
            if (level_load)                  ttl <= depth;
            else if (next_level && ttl != '0) ttl <= ttl - DPW'(1);
            // Compares against the register value, so a same-cycle swap cannot affect routing.
            if (accept) pt.go_left <= (pt_axis < ctr_axis);
            if (do_parent) begin
                parent_out <= center;
                center     <= parent_in;
            end else if (do_child) begin
                child_out <= center;
                center    <= child_in;
            end
            case (state_q)
                IDLE: begin
                    sums    <= sum_nxt;
                    count   <= cnt_nxt;
                    bit_cnt <= '0;
                    for (int d = 0; d < DIM; d++) rem[d] <= '0;
                    if (update_start && cnt_nxt == '0) begin
                        done   <= 1'b1;
                        stable <= 1'b1;
                    end
                end
                DIVIDE: begin
                    bit_cnt <= bit_cnt + BW'(1);
                    for (int d = 0; d < DIM; d++) begin
                        rem[d]  <= q_bit[d] ? CW'(trial[d] - {1'b0, count}) : trial[d][CW-1:0];
                        sums[d] <= {sums[d][AW-2:0], q_bit[d]};
                    end
                end
                COMMIT: begin
                    stable <= &eq;
                    done   <= 1'b1;
                    count  <= '0;
                    for (int d = 0; d < DIM; d++) begin
                        center[d*DW +: DW] <= sums[d][DW-1:0];
                        sums[d]            <= '0;
                    end
                end
                default: ;
            endcase
        end else begin
            done <= 1'b0;
        end
    end
endmodule

// File: doc/kd_cluster_pe.md
Name: kd_cluster_pe

Overview:
Next-generation k-d tree cluster processing element, parametrised in dimension count, coordinate width, point capacity and tree depth.
Holds one cluster center and routes incoming points left/right on the depth-selected split axis.
Accumulates per-dimension sums of its assigned points and computes a new centroid with a serial divider, reporting convergence.
Swaps centers with its parent or child node under a time-to-live budget during tree re-sorting.

Parameters:
DIM, 3, number of dimensions (>=1)
DW, 8, bits per coordinate (unsigned)
MAX_N, 1024, maximum points accumulated per iteration
MAX_DEPTH, 16, maximum tree depth
INIT_CENTER, 0, center value loaded on reset (DIM*DW bits)
Derived: CW=$clog2(MAX_N+1); AW=DW+CW; DPW=$clog2(MAX_DEPTH+1).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
en  in  1  global enable; when 0 all state holds and pulses are suppressed
depth  in  DPW  tree level of this node
level_load  in  1  load ttl <= depth
next_level  in  1  decrement ttl, saturating at 0
pt_valid  in  1  point offered
pt_ready  out  1  point accepted when pt_valid&&pt_ready
pt_in  in  DIM*DW  point; dimension d at [d*DW +: DW]
pt_assign  in  1  qualifies pt_valid: accumulate point (1) or route only (0)
go_left  out  1  registered: pt[axis] < center[axis] for last accepted point
update_start  in  1  begin centroid update
busy  out  1  high in DIVIDE
done  out  1  one-cycle pulse when update completes
stable  out  1  new centroid equalled old one (valid from done)
count  out  CW  points accumulated this iteration
parent_swap  in  1  request swap with parent
child_swap  in  1  request swap with child
parent_in  in  DIM*DW  parent's center
child_in  in  DIM*DW  child's center
parent_out  out  DIM*DW  center handed to parent
child_out  out  DIM*DW  center handed to child
center  out  DIM*DW  current center
child_depth  out  DPW  depth+1, combinational

Behaviour:
- Reset: center=INIT_CENTER; sums=0; count=0; ttl=0; parent_out=child_out=0; go_left=0; stable=0; done=0; state=IDLE. Reset mid-DIVIDE aborts; no done.
- States: IDLE (accept points/swaps) -> DIVIDE on update_start -> IDLE after AW cycles + 1 commit cycle.
- pt_ready = (state==IDLE) && en && (count<MAX_N).
- Axis = depth mod DIM. On accept: go_left updates next cycle. If pt_assign is set, sums[d] += pt[d] and count += 1 in the same edge.
- At count==MAX_N, pt_ready=0 and further points stall; no wrap.
- update_start in IDLE with count==0: no DIVIDE; next cycle done=1, stable=1, center unchanged.
- DIVIDE: restoring division sums[d]/count, all DIM lanes in parallel, one quotient bit per cycle, MSB first, AW cycles, truncating.
- Quotient is stored in DW bits; it cannot overflow because the mean is at most 2^DW-1.
- Commit cycle:
  - stable = (quotient==center) for all d.
  - center <= quotient.
  - sums, count cleared.
  - done pulses for 1 cycle.
- update_start while busy is ignored.
- ttl: level_load wins over next_level if both are asserted. Otherwise next_level gives ttl <= ttl-1, saturating at 0.
- Swaps are allowed only in IDLE with ttl!=0; ignored otherwise.
- parent_swap: parent_out <= center; center <= parent_in (same edge, old value exported).
- child_swap: child_out <= center; center <= child_in.
- If both parent_swap and child_swap are asserted, parent_swap wins and child_swap is dropped.
- A swap does not alter ttl, sums or count.
- A swap and a point accept in the same cycle: go_left uses the pre-swap center.
- Outputs parent_out/child_out hold their value until the next swap of that kind.
- en=0: all registers hold; done is not asserted; pt_ready=0.

Test Plan:
- Reset with INIT_CENTER={30,20,10} -> center={30,20,10}, count=0, pt_ready=1, parent_out=0.
- depth=1, center={30,20,10}, accept pt={5,25,0} -> axis=1, go_left=0. Then pt={5,15,0} -> go_left=1.
- Assign points {10,20,30},{20,40,50},{31,0,1} then update_start:
  - busy for AW cycles, then done.
  - center={20,20,27}, stable=0, count=0.
  - A repeat with the same points gives stable=1.
- Fill to MAX_N=4 points -> pt_ready=0 while pt_valid is held; after update, pt_ready returns to 1.
- level_load with depth=2 then parent_swap, parent_in={1,2,3} -> parent_out=old center, center={1,2,3}.
  - Two next_level pulses, then child_swap -> ignored (ttl=0).
- parent_swap&&child_swap together -> only the parent exchange occurs.
- update_start pulsed during DIVIDE -> ignored.
- rst mid-DIVIDE -> reset values, no done pulse.
